// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore sequencer with memory wait-state
// handshake, configurable branch decode and a sticky illegal-instruction trap.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC + 4 when memory is ready
// DECODE   | OldPC + imm into ALUOut (branch target), dispatch on op
// MEMADR   | RD1 + imm -> ALUOut (load/store address)
// MEMREAD  | read data at ALUOut, wait for memory
// MEMWB    | write loaded data to rd
// MEMWRITE | write RD2 at ALUOut, wait for memory
// EXECUTER | RD1 op RD2
// EXECUTEI | RD1 op imm
// ALUWB    | write ALUOut to rd
// BRANCH   | compare RD1/RD2, PC <= target when taken
// JAL      | PC <= target, OldPC + 4 -> ALUOut (link)
// ILLEGAL  | trap, absorbing until reset
module multicycle_controller #(
  parameter int MEM_WAIT   = 1,
  parameter int BRANCH_EXT = 1,
  parameter int STATE_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  input  logic               Lt,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t     state_q, state_d;
  logic       illegal_q;
  logic       ready;
  logic       pc_update, branch, cond;
  logic       ir_write, mem_write, reg_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       br_ok, alu_f3_ok;

  assign ready = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

  assign br_ok = (funct3 == 3'b000) ||
                 ((BRANCH_EXT != 0) &&
                  (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b101));

  assign alu_f3_ok = !(funct3 == 3'b001 || funct3 == 3'b011 || funct3 == 3'b101);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (ready) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = alu_f3_ok ? S_EXECUTER : S_ILLEGAL;
          OP_ITYPE:          state_d = alu_f3_ok ? S_EXECUTEI : S_ILLEGAL;
          OP_JAL:            state_d = S_JAL;
          OP_BR:             state_d = br_ok ? S_BRANCH : S_ILLEGAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_ILLEGAL;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = Zero;
      3'b001:  cond = (BRANCH_EXT != 0) && !Zero;
      3'b100:  cond = (BRANCH_EXT != 0) && Lt;
      3'b101:  cond = (BRANCH_EXT != 0) && !Lt;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b100:  alu_control = 3'b100;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_STORE: imm_src = 2'b01;
      OP_BR:    imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  // Everything is held at zero while reset is low so an aborted instruction
  // cannot write anything.
  assign PCWrite       = reset & (pc_update | (branch & cond));
  assign IRWrite       = reset & ir_write;
  assign MemWrite      = reset & mem_write;
  assign RegWrite      = reset & reg_write;
  assign AdrSrc        = reset & adr_src;
  assign ResultSrc     = reset ? result_src  : 2'b00;
  assign ALUSrcA       = reset ? alu_src_a   : 2'b00;
  assign ALUSrcB       = reset ? alu_src_b   : 2'b00;
  assign ImmSrc        = reset ? imm_src     : 2'b00;
  assign ALUControl    = reset ? alu_control : 3'b000;
  assign illegal_instr = reset & illegal_q;
  assign state_dbg     = reset ? STATE_W'(state_q) : '0;

endmodule
